// File: rtl/vga_scroll_sequencer_if.sv
// Host command channel of the VGA scroll sequencer: a single-slot valid/ready
// command bus carrying a 2-bit opcode and an 8-bit argument.
interface vga_scroll_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;

    modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/vga_scroll_sequencer.sv
// Frame-synchronous sequencer for the colour-bar generator: shadows one host
// command, applies it at frame_tick, then advances scroll and auto pattern rotation.
module vga_scroll_sequencer #(
    parameter int NUM_PATTERNS  = 4,
    parameter int PERIOD        = 630,
    parameter int DWELL_DEFAULT = 150
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick_i,
    vga_scroll_sequencer_if.slave  cmd,
    output logic [1:0]             pattern_sel_o,
    output logic [9:0]             scroll_offset_o,
    output logic [1:0]             mode_o,
    output logic                   cfg_update_o
);
    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_PAUSE  = 2'd2
    } mode_e;

    localparam logic [1:0]  PAT_MAX = 2'(NUM_PATTERNS - 1);
    localparam logic [10:0] PER     = 11'(PERIOD);

    mode_e       mode_q, mode_d;
    logic [1:0]  pat_q, pat_d;
    logic [9:0]  off_q, off_d;
    logic [3:0]  step_q, step_d;
    logic        dir_q, dir_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  arg_q, arg_d;
    logic        upd_q, upd_d;
    logic [10:0] fwd_sum;
    logic        xfer;

    // Handshake: a command transfers on any cycle with cmd_valid && cmd_ready;
    // cmd_ready is low while the shadow slot is occupied or reset is asserted.
    assign cmd.cmd_ready = !pend_q && !rst;
    assign xfer          = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        mode_d  = mode_q;
        pat_d   = pat_q;
        off_d   = off_q;
        step_d  = step_q;
        dir_d   = dir_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        op_d    = op_q;
        arg_d   = arg_q;
        upd_d   = 1'b0;
        fwd_sum = 11'd0;

        if (xfer) begin
            pend_d = 1'b1;
            op_d   = cmd.cmd_op;
            arg_d  = cmd.cmd_arg;
        end

        if (frame_tick_i) begin
            // The pending command is applied first so it governs this same tick.
            if (pend_q) begin
                pend_d = 1'b0;
                upd_d  = 1'b1;
                case (op_q)
                    2'd0: begin
                        pat_d = (arg_q[1:0] > PAT_MAX) ? PAT_MAX : arg_q[1:0];
                        if (mode_q == MODE_AUTO) cnt_d = 8'd0;
                    end
                    2'd1: begin
                        dir_d  = arg_q[7];
                        step_d = arg_q[3:0];
                    end
                    2'd2: begin
                        dwell_d = (arg_q == 8'd0) ? 8'd1 : arg_q;
                        cnt_d   = 8'd0;
                    end
                    default: begin
                        if (arg_q[1:0] != 2'd3) mode_d = mode_e'(arg_q[1:0]);
                        if (arg_q[1:0] == 2'd1) cnt_d = 8'd0;
                    end
                endcase
            end

            if (mode_d != MODE_PAUSE) begin
                if (!dir_d) begin
                    fwd_sum = {1'b0, off_q} + {7'b0, step_d};
                    off_d   = (fwd_sum >= PER) ? 10'(fwd_sum - PER) : fwd_sum[9:0];
                end else if (off_q < {6'b0, step_d}) begin
                    off_d = 10'({1'b0, off_q} + PER - {7'b0, step_d});
                end else begin
                    off_d = off_q - {6'b0, step_d};
                end
            end

            if (mode_d == MODE_AUTO) begin
                if (cnt_d == dwell_d - 8'd1) begin
                    pat_d = (pat_d == PAT_MAX) ? 2'd0 : pat_d + 2'd1;
                    cnt_d = 8'd0;
                end else begin
                    cnt_d = cnt_d + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_MANUAL;
            pat_q   <= 2'd0;
            off_q   <= 10'd0;
            step_q  <= 4'd1;
            dir_q   <= 1'b0;
            dwell_q <= 8'(DWELL_DEFAULT);
            cnt_q   <= 8'd0;
            pend_q  <= 1'b0;
            op_q    <= 2'd0;
            arg_q   <= 8'd0;
            upd_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            off_q   <= off_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            upd_q   <= upd_d;
        end
    end

    assign pattern_sel_o   = pat_q;
    assign scroll_offset_o = off_q;
    assign mode_o          = mode_q;
    assign cfg_update_o    = upd_q;
endmodule
